// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I data-memory slice.
//   XLEN            : data path width
//   F3_*            : RV32I load/store funct3 codes
//   dmem_state_t    : controller FSM state encoding (IDLE, WAIT, RESP)
//   sat_inc16       : 16-bit saturating increment used by the statistics counters
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rv32_dmem_ram.sv
// Synchronous single-port RAM, 2**DEPTH_LOG2 x 32 bits, byte write enables,
// registered read. Contents are not reset.
//   clk   : clock
//   en    : access enable (read and/or write this edge)
//   we    : per-byte write enable, bit i writes wdata[8i+7:8i]
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after an enabled access
module rv32_dmem_ram
  import rv32_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/rv32_dmem_ctrl.sv
// RV32I data-memory controller: valid/ready request channel, configurable wait
// states, byte/half/word lane steering, sign/zero extension and fault detection.
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata : request fields, captured at acceptance
//   rsp_valid             : one-cycle response pulse
//   rsp_rdata/rsp_error   : load result (extended) / fault flag
//   stat_loads/stores/errors : saturating completion counters
// Build option: define DMEM_STATS_EN to generate the statistics counters;
// otherwise the stat_* outputs are tied to zero.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | legal access accepted, counting down wait states
// RESP  | response cycle, rsp_valid high
module rv32_dmem_ctrl
  import rv32_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic [15:0]     stat_loads,
  output logic [15:0]     stat_stores,
  output logic [15:0]     stat_errors
);

  localparam int AW = DEPTH_LOG2 + 2;

  dmem_state_t     state, state_nxt;
  logic [3:0]      wait_cnt;
  logic            wr_q, err_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;

  logic            accept, req_err, illegal_f3, misaligned, out_of_range;
  logic            ram_en;
  logic [3:0]      ram_we, lane_be;
  logic [XLEN-1:0] ram_wdata, ram_rdata, load_val;
  logic [XLEN-1:0] shifted;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    illegal_f3   = req_write ? (req_funct3 > F3_W)
                             : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >> AW) != '0;
    req_err      = illegal_f3 || misaligned || out_of_range;
  end

  // State register, wait counter and request capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q     <= req_write;
        err_q    <= req_err;
        f3_q     <= req_funct3;
        addr_q   <= req_addr[AW-1:0];
        wdata_q  <= req_wdata;
        wait_cnt <= req_err ? 4'd0 : WAIT_STATES[3:0];
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_err ? RESP : WAIT;
      WAIT:    if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Store lane steering: data is replicated so the byte enables pick the lane
  always_comb begin
    lane_be   = 4'b0000;
    ram_wdata = wdata_q;
    case (f3_q)
      F3_B: begin
        lane_be   = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        lane_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      F3_W:    lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  // RAM is touched only on the edge that moves WAIT -> RESP; error accesses never enter WAIT
  assign ram_en = (state == WAIT) && (wait_cnt == 4'd0);
  assign ram_we = (ram_en && wr_q) ? lane_be : 4'b0000;

  rv32_dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_q[AW-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    shifted  = ram_rdata >> {addr_q[1:0], 3'b000};
    load_val = '0;
    case (f3_q)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_val = {24'd0, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_val = {16'd0, shifted[15:0]};
      F3_W:    load_val = ram_rdata;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_error = (state == RESP) && err_q;
    rsp_rdata = ((state == RESP) && !err_q && !wr_q) ? load_val : '0;
  end

`ifdef DMEM_STATS_EN
  logic [15:0] n_loads, n_stores, n_errors;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_loads  <= 16'd0;
      n_stores <= 16'd0;
      n_errors <= 16'd0;
    end else if (state == RESP) begin
      if (err_q)     n_errors <= sat_inc16(n_errors);
      else if (wr_q) n_stores <= sat_inc16(n_stores);
      else           n_loads  <= sat_inc16(n_loads);
    end
  end

  assign stat_loads  = n_loads;
  assign stat_stores = n_stores;
  assign stat_errors = n_errors;
`else
  assign stat_loads  = 16'd0;
  assign stat_stores = 16'd0;
  assign stat_errors = 16'd0;
`endif

endmodule

// File: tb/tb_rv32_dmem_ctrl.sv
module tb_rv32_dmem_ctrl;

  localparam int DL2 = 10;
  localparam int WS  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [15:0] stat_loads, stat_stores, stat_errors;

  rv32_dmem_ctrl #(.DEPTH_LOG2(DL2), .WAIT_STATES(WS)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errors (stat_errors)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;
  int cnt_ld = 0, cnt_st = 0, cnt_er = 0;

  // Reference memory: words 0x00..0x3F, the only legal region the bench uses
  logic [31:0] mdl [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (wr && f3 > 3'd2) return 1'b1;
    if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
    if (a >= (32'd4 << DL2)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, b, h;
    w = mdl[a[5:2]];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w, m;
    int sh;
    w = mdl[a[5:2]];
    if (f3 == 3'd0) begin
      sh = 8 * (a % 4);
      m  = 32'hFF << sh;
      w  = (w & ~m) | ((wd & 32'hFF) << sh);
    end else if (f3 == 3'd1) begin
      sh = 16 * ((a / 2) % 2);
      m  = 32'hFFFF << sh;
      w  = (w & ~m) | ((wd & 32'hFFFF) << sh);
    end else begin
      w = wd;
    end
    mdl[a[5:2]] = w;
  endtask

  task automatic do_req(input string tag, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    bit exp_err, seen;
    int exp_lat, lat, guard;
    exp_err = model_err(wr, f3, a);
    exp_lat = exp_err ? 1 : WS + 2;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = $urandom_range(0, 1);
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    seen = 0;
    lat  = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        lat  = k;
      end else begin
        check({tag, " busy_ready"}, {31'd0, req_ready}, 32'd0);
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    if (seen) begin
      check({tag, " rdata"}, rsp_rdata, (exp_err || wr) ? 32'd0 : model_load(f3, a));
      check({tag, " error"}, {31'd0, rsp_error}, {31'd0, exp_err});
      check({tag, " resp_ready"}, {31'd0, req_ready}, 32'd0);
    end
    if (exp_err) cnt_er++;
    else if (wr) begin
      cnt_st++;
      model_store(f3, a, wd);
    end else cnt_ld++;
    @(negedge clk);
    check({tag, " pulse_end"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " back_idle"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, " valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " rdata"}, rsp_rdata, 32'd0);
    check({tag, " error"}, {31'd0, rsp_error}, 32'd0);
    check({tag, " stat_loads"}, {16'd0, stat_loads}, 32'd0);
    check({tag, " stat_stores"}, {16'd0, stat_stores}, 32'd0);
    check({tag, " stat_errors"}, {16'd0, stat_errors}, 32'd0);
  endtask

  task automatic check_stats(input string tag);
    int el, es, ee;
`ifdef DMEM_STATS_EN
    el = (cnt_ld > 65535) ? 65535 : cnt_ld;
    es = (cnt_st > 65535) ? 65535 : cnt_st;
    ee = (cnt_er > 65535) ? 65535 : cnt_er;
`else
    el = 0;
    es = 0;
    ee = 0;
`endif
    check({tag, " stat_loads"}, {16'd0, stat_loads}, el);
    check({tag, " stat_stores"}, {16'd0, stat_stores}, es);
    check({tag, " stat_errors"}, {16'd0, stat_errors}, ee);
  endtask

  initial begin
    logic [31:0] ra;
    int r;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) do_req("init_sw", 1'b1, 3'd2, 32'(i * 4), $urandom);

    do_req("sw_10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req("lw_10", 1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_10 literal", mdl[4], 32'hDEADBEEF);
    do_req("lb_13",  1'b0, 3'd0, 32'h13, 32'h0);
    do_req("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0);
    do_req("lh_12",  1'b0, 3'd1, 32'h12, 32'h0);
    do_req("lhu_10", 1'b0, 3'd5, 32'h10, 32'h0);
    do_req("sb_11",  1'b1, 3'd0, 32'h11, 32'hFFFFFF55);
    do_req("lw_sb",  1'b0, 3'd2, 32'h10, 32'h0);
    do_req("sh_12",  1'b1, 3'd1, 32'h12, 32'hABCD1234);
    do_req("lw_sh",  1'b0, 3'd2, 32'h10, 32'h0);
    check("sh_sb literal", mdl[4], 32'h123455EF);

    do_req("err_lw_11",  1'b0, 3'd2, 32'h11, 32'h0);
    do_req("err_lh_13",  1'b0, 3'd1, 32'h13, 32'h0);
    do_req("err_f3_3",   1'b0, 3'd3, 32'h10, 32'h0);
    do_req("err_sw_1000", 1'b1, 3'd2, 32'h1000, 32'h11111111);
    do_req("err_sb_f3_4", 1'b1, 3'd4, 32'h10, 32'h22222222);
    do_req("lw_after_err", 1'b0, 3'd2, 32'h10, 32'h0);

    // Reset during WAIT of a store must abort it without touching RAM
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    reset  = 1'b0;
    cnt_ld = 0;
    cnt_st = 0;
    cnt_er = 0;
    do_req("lw_20_after_reset", 1'b0, 3'd2, 32'h20, 32'h0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      ra = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) ra = $urandom | 32'h8000_0000;
      else             ra = $urandom_range(0, 63);
      do_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
    end
    for (int i = 0; i < 16; i++) do_req("final_lw", 1'b0, 3'd2, 32'(i * 4), 32'h0);

    check_stats("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
